// File: rtl/bheap_seq.sv
// bheap_seq: loads a shift-chain heap over the heap bus, starts its compare-pass counter, polls it to zero, then unloads the words.
// Optional WAIT watchdog and Timeout port when BHEAP_SEQ_TIMEOUT_EN is defined.
module bheap_seq #(
  parameter int NODES           = 3,
  parameter int WIDTH           = 32,
  parameter int CWIDTH          = 8,
  parameter int CTRL_ID         = 1,
  parameter int SCAN_ID         = 0,
  parameter int GlobalAddrWidth = 8,
  parameter int GlobalDataWidth = 32
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic [CWIDTH-1:0]          Passes,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [WIDTH-1:0]           InData,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [WIDTH-1:0]           OutData,
  output logic                       Busy,
  output logic                       Done,
`ifdef BHEAP_SEQ_TIMEOUT_EN
  output logic                       Timeout,
`endif
  output logic                       HRD,
  output logic                       HWR,
  output logic [GlobalAddrWidth-1:0] HAddr,
  output logic [GlobalDataWidth-1:0] HDataOut,
  input  logic [GlobalDataWidth-1:0] HDataIn
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KICK,
    WAIT,
    UNLOAD,
    FINISH
  } state_t;

  localparam logic [7:0]                 LAST_WORD = 8'(NODES - 1);
  localparam logic [GlobalAddrWidth-1:0] ADDR_SCAN = GlobalAddrWidth'(SCAN_ID);
  localparam logic [GlobalAddrWidth-1:0] ADDR_CTRL = GlobalAddrWidth'(CTRL_ID);

  state_t            state_q, state_d;
  logic [CWIDTH-1:0] passes_q, passes_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              out_vld_q, out_vld_d;
  logic [WIDTH-1:0]  out_dat_q, out_dat_d;

`ifdef BHEAP_SEQ_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic [15:0] wd_inc;
  logic        to_q, to_d;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      passes_q  <= '0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
`ifdef BHEAP_SEQ_TIMEOUT_EN
      wd_q      <= '0;
      to_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      passes_q  <= passes_d;
      cnt_q     <= cnt_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
`ifdef BHEAP_SEQ_TIMEOUT_EN
      wd_q      <= wd_d;
      to_q      <= to_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    passes_d  = passes_q;
    cnt_d     = cnt_q;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    InReady   = 1'b0;
    HRD       = 1'b0;
    HWR       = 1'b0;
    HAddr     = '0;
    HDataOut  = '0;
    Done      = 1'b0;
`ifdef BHEAP_SEQ_TIMEOUT_EN
    wd_d      = wd_q;
    wd_inc    = wd_q + 16'd1;
    to_d      = to_q;
`endif

    case (state_q)
      IDLE: begin
        if (Start) begin
          passes_d = Passes;
          cnt_d    = '0;
          state_d  = LOAD;
        end
      end

      LOAD: begin
        InReady = 1'b1;
        if (InValid) begin
          HWR      = 1'b1;
          HAddr    = ADDR_SCAN;
          HDataOut = GlobalDataWidth'(InData);
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = KICK;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      KICK: begin
        // A zero-pass job skips the counter entirely; polling would otherwise see 0 immediately anyway.
        if (passes_q == '0) begin
          state_d = UNLOAD;
        end else begin
          HWR      = 1'b1;
          HAddr    = ADDR_CTRL;
          HDataOut = GlobalDataWidth'(passes_q);
          state_d  = WAIT;
`ifdef BHEAP_SEQ_TIMEOUT_EN
          wd_d     = '0;
`endif
        end
      end

      WAIT: begin
        HRD   = 1'b1;
        HAddr = ADDR_CTRL;
        if (HDataIn[CWIDTH-1:0] == '0) begin
          state_d = UNLOAD;
        end
`ifdef BHEAP_SEQ_TIMEOUT_EN
        else begin
          wd_d = wd_inc;
          if (wd_inc == 16'hFFFF) begin
            to_d    = 1'b1;
            state_d = FINISH;
          end
        end
`endif
      end

      UNLOAD: begin
        // One read per word; the next read waits until the held word has been taken.
        if (!out_vld_q) begin
          HRD       = 1'b1;
          HAddr     = ADDR_SCAN;
          out_dat_d = HDataIn[WIDTH-1:0];
          out_vld_d = 1'b1;
        end else if (OutReady) begin
          out_vld_d = 1'b0;
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = FINISH;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      FINISH: begin
        Done    = 1'b1;
        state_d = IDLE;
`ifdef BHEAP_SEQ_TIMEOUT_EN
        to_d    = 1'b0;
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  assign Busy     = (state_q != IDLE);
  assign OutValid = out_vld_q;
  assign OutData  = out_dat_q;
`ifdef BHEAP_SEQ_TIMEOUT_EN
  assign Timeout  = (state_q == FINISH) && to_q;
`endif

endmodule

// File: tb/tb_bheap_seq.sv
// Bench for bheap_seq: heap-slave model on the bus, job table, corner sequences, randomized jobs vs a sort-based reference.
module tb_bheap_seq;
  localparam int NODES = 3;
  localparam logic [7:0] SCAN = 8'd0;
  localparam logic [7:0] CTRL = 8'd1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  Passes = '0;
  logic        InValid = 1'b0;
  logic [31:0] InData = '0;
  logic        OutReady = 1'b0;
  logic        InReady, OutValid, Busy, Done, HRD, HWR;
  logic [31:0] OutData, HDataOut, HDataIn;
  logic [7:0]  HAddr;
`ifdef BHEAP_SEQ_TIMEOUT_EN
  logic        Timeout;
`endif

  bheap_seq dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Passes(Passes),
    .InValid(InValid), .InReady(InReady), .InData(InData),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .Busy(Busy), .Done(Done),
`ifdef BHEAP_SEQ_TIMEOUT_EN
    .Timeout(Timeout),
`endif
    .HRD(HRD), .HWR(HWR), .HAddr(HAddr), .HDataOut(HDataOut), .HDataIn(HDataIn)
  );

  always #5 Clk = ~Clk;

  // Heap slave: scan writes shift in at [0], scan reads pop [NODES-1], each pass is one bubble step toward the head.
  typedef logic [NODES-1:0][31:0] chain_t;
  chain_t     chain = '0;
  logic [7:0] hcnt = '0;
  logic       force_one = 1'b0;

  function automatic chain_t bubble(input chain_t c);
    chain_t r = c;
    logic [31:0] t;
    for (int i = 0; i < NODES - 1; i++)
      if (r[i] > r[i+1]) begin t = r[i]; r[i] = r[i+1]; r[i+1] = t; end
    return r;
  endfunction

  initial forever begin
    @(posedge Clk);
    if (Reset) hcnt <= '0;
    else if (HWR && HAddr == CTRL) hcnt <= HDataOut[7:0];
    else if (HWR && HAddr == SCAN) chain <= {chain[NODES-2:0], HDataOut};
    else if (HRD && HAddr == SCAN) chain <= {chain[NODES-2:0], 32'd0};
    else if (hcnt != 0) begin chain <= bubble(chain); hcnt <= hcnt - 8'd1; end
  end

  assign HDataIn = force_one ? 32'd1 :
                   (!HRD ? 32'hA5A5_5A5A : ((HAddr == CTRL) ? {24'd0, hcnt} : chain[NODES-1]));

  int compares = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor, sampled on the falling edge.
  int          viol, ctrl_wr, rd_cnt, wait_rd, done_cnt;
  logic [31:0] ctrl_dat;
  logic [31:0] wr_q[$];
  logic [31:0] out_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_dat = '0;

  task automatic clear_mon();
    viol = 0; ctrl_wr = 0; rd_cnt = 0; wait_rd = 0; done_cnt = 0; ctrl_dat = '0;
    wr_q.delete(); out_q.delete();
  endtask

  initial forever begin
    @(negedge Clk);
    if (HRD && HWR) viol++;
    if (!HRD && !HWR && (HAddr != 0 || HDataOut != 0)) viol++;
    if (HWR && HAddr == SCAN) begin
      if (!InValid) viol++;
      wr_q.push_back(HDataOut);
    end
    if (HWR && HAddr == CTRL) begin ctrl_wr++; ctrl_dat = HDataOut; end
    if (HRD && HAddr == SCAN) begin rd_cnt++; if (OutValid) viol++; end
    if (HRD && HAddr == CTRL) wait_rd++;
    if (prev_stall && (!OutValid || OutData != prev_dat)) viol++;
    prev_stall = OutValid && !OutReady;
    prev_dat = OutData;
    if (OutValid && OutReady) out_q.push_back(OutData);
    if (Done) done_cnt++;
  end

  // mode: 0 random valid/ready, 1 InValid toggling, 2 ten-cycle OutReady stall, 3 full speed
  typedef struct packed {
    logic [7:0]        p;
    logic [2:0][31:0]  d;
    logic [2:0][31:0]  e;
    logic [1:0]        mode;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] p, input logic [31:0] a, b, c, x, y, z,
                              input logic [1:0] m);
    vec_t v;
    v.p = p; v.d[0] = a; v.d[1] = b; v.d[2] = c;
    v.e[0] = x; v.e[1] = y; v.e[2] = z; v.mode = m;
    return v;
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, " InReady"}, {31'd0, InReady}, 32'd0);
    chk({tag, " OutValid"}, {31'd0, OutValid}, 32'd0);
    chk({tag, " Busy"}, {31'd0, Busy}, 32'd0);
    chk({tag, " Done"}, {31'd0, Done}, 32'd0);
    chk({tag, " HRD_HWR"}, {30'd0, HRD, HWR}, 32'd0);
    chk({tag, " OutData"}, OutData, 32'd0);
    chk({tag, " HAddr"}, {24'd0, HAddr}, 32'd0);
    chk({tag, " HDataOut"}, HDataOut, 32'd0);
  endtask

  // Called right after a rising edge (+1); returns at the same phase.
  task automatic run_job(input vec_t v, input string tag);
    int idx = 0;
    int cyc = 0;
    int stall_left = 0;
    bit stalled = 0;
    bit got_done = 0;
    clear_mon();
    Start = 1'b1; Passes = v.p;
    @(posedge Clk); #1;
    Start = 1'b0; Passes = ~v.p;
    while (!got_done && cyc < 4000) begin
      if (idx < NODES) begin
        case (v.mode)
          2'd0: InValid = ($urandom_range(3) != 0);
          2'd1: InValid = (cyc % 2 == 0);
          default: InValid = 1'b1;
        endcase
        InData = v.d[idx];
      end else begin
        InValid = 1'b0;
      end
      if (v.mode == 2'd2 && OutValid && !stalled) begin stalled = 1; stall_left = 10; end
      OutReady = (stall_left > 0) ? 1'b0 : ((v.mode == 2'd0) ? 1'($urandom_range(1)) : 1'b1);
      if (stall_left > 0) stall_left--;
      @(negedge Clk);
      if (InValid && InReady) idx++;
      if (Done) got_done = 1;
      @(posedge Clk); #1;
      cyc++;
    end
    InValid = 1'b0; OutReady = 1'b0;
    @(negedge Clk);
    chk({tag, " done_seen"}, {31'd0, got_done}, 32'd1);
    chk({tag, " done_pulses"}, done_cnt, 32'd1);
    chk({tag, " busy_after"}, {31'd0, Busy}, 32'd0);
    chk({tag, " scan_writes"}, wr_q.size(), NODES);
    for (int i = 0; i < NODES; i++)
      chk($sformatf("%s wr%0d", tag, i), (i < wr_q.size()) ? wr_q[i] : 32'hDEAD_0000, v.d[i]);
    chk({tag, " ctrl_writes"}, ctrl_wr, (v.p != 0) ? 32'd1 : 32'd0);
    if (v.p != 0) chk({tag, " ctrl_data"}, ctrl_dat, {24'd0, v.p});
    chk({tag, " scan_reads"}, rd_cnt, NODES);
    chk({tag, " out_count"}, out_q.size(), NODES);
    for (int i = 0; i < NODES; i++)
      chk($sformatf("%s out%0d", tag, i), (i < out_q.size()) ? out_q[i] : 32'hDEAD_0000, v.e[i]);
    chk({tag, " bus_rules"}, viol, 32'd0);
    if (v.mode == 2'd2) chk({tag, " stall_seen"}, {31'd0, stalled}, 32'd1);
    @(posedge Clk); #1;
  endtask

  vec_t vt[7];

  initial begin
    vt[0] = mk(8'd2,   32'd5, 32'd9, 32'd1,  32'd9, 32'd5, 32'd1, 2'd3);
    vt[1] = mk(8'd0,   32'd5, 32'd9, 32'd1,  32'd5, 32'd9, 32'd1, 2'd3);
    vt[2] = mk(8'd2,   32'd7, 32'd3, 32'd8,  32'd8, 32'd7, 32'd3, 2'd1);
    vt[3] = mk(8'd1,   32'd4, 32'd8, 32'd6,  32'd8, 32'd4, 32'd6, 2'd2);
    vt[4] = mk(8'd3,   32'hFFFF_FFFF, 32'd0, 32'h8000_0000,
                       32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 2'd0);
    vt[5] = mk(8'd255, 32'd1, 32'd2, 32'd3,  32'd3, 32'd2, 32'd1, 2'd3);
    vt[6] = mk(8'd0,   32'd10, 32'd20, 32'd30, 32'd10, 32'd20, 32'd30, 2'd2);

    clear_mon();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_outputs_zero("in_reset");
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    check_outputs_zero("after_reset");
    @(posedge Clk); #1;

    for (int k = 0; k < 7; k++) run_job(vt[k], $sformatf("vec%0d", k));

    // Reset in the middle of LOAD, after two of three words.
    clear_mon();
    Start = 1'b1; Passes = 8'd3;
    @(posedge Clk); #1;
    Start = 1'b0; InValid = 1'b1; InData = 32'h11;
    @(posedge Clk); #1;
    InData = 32'h22;
    @(posedge Clk); #1;
    InValid = 1'b0;
    @(negedge Clk);
    chk("midload busy_before", {31'd0, Busy}, 32'd1);
    chk("midload words_before", wr_q.size(), 32'd2);
    @(posedge Clk); #1;
    Reset = 1'b1; InValid = 1'b1; InData = 32'h33;
    @(negedge Clk);
    check_outputs_zero("midload_reset");
    @(posedge Clk); #1;
    Reset = 1'b0;
    repeat (4) @(posedge Clk);
    #1 InValid = 1'b0;
    @(negedge Clk);
    chk("midload no_more_writes", wr_q.size(), 32'd2);
    chk("midload idle", {31'd0, Busy}, 32'd0);
    @(posedge Clk); #1;

    // Randomized jobs against a sort-based reference.
    for (int r = 0; r < 15; r++) begin
      vec_t v;
      logic [31:0] s[3];
      logic [31:0] t;
      v.p = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom_range(2, 12));
      for (int i = 0; i < NODES; i++)
        v.d[i] = ($urandom_range(1) == 0) ? 32'($urandom_range(7)) : $urandom;
      for (int i = 0; i < NODES; i++) s[i] = v.d[i];
      if (v.p != 0)
        for (int a = 0; a < NODES; a++)
          for (int b = a + 1; b < NODES; b++)
            if (s[b] > s[a]) begin t = s[a]; s[a] = s[b]; s[b] = t; end
      for (int i = 0; i < NODES; i++) v.e[i] = s[i];
      v.mode = 2'($urandom_range(3));
      run_job(v, $sformatf("rnd%0d", r));
    end

`ifdef BHEAP_SEQ_TIMEOUT_EN
    begin
      int cyc = 0;
      int idx = 0;
      bit seen = 0;
      clear_mon();
      force_one = 1'b1;
      Start = 1'b1; Passes = 8'd5;
      @(posedge Clk); #1;
      Start = 1'b0;
      while (!seen && cyc < 70000) begin
        InValid = (idx < NODES);
        InData = 32'(idx);
        @(negedge Clk);
        if (InValid && InReady) idx++;
        if (Done) begin
          seen = 1;
          chk("timeout pulse", {31'd0, Timeout}, 32'd1);
        end
        @(posedge Clk); #1;
        cyc++;
      end
      InValid = 1'b0;
      chk("timeout done_seen", {31'd0, seen}, 32'd1);
      chk("timeout wait_cycles", wait_rd, 32'd65535);
      chk("timeout no_unload", rd_cnt, 32'd0);
      @(negedge Clk);
      chk("timeout idle", {31'd0, Busy}, 32'd0);
      chk("timeout one_cycle", {31'd0, Timeout}, 32'd0);
      force_one = 1'b0;
      @(posedge Clk); #1;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule

// File: doc/bheap_seq.md
BHEAP_SEQ -- requirements
Module: bheap_seq

Interface
REQ-001 SHALL have parameter NODES, default 3, meaning number of heap registers on the scan chain (1..255).
REQ-002 SHALL have parameter WIDTH, default 32, meaning heap key width (≤ GlobalDataWidth).
REQ-003 SHALL have parameter CWIDTH, default 8, meaning width of the heap controller pass counter.
REQ-004 SHALL have parameter CTRL_ID, default 1, meaning the heap controller's counter address.
REQ-005 SHALL have parameter SCAN_ID, default 0, meaning the heap controller's scan-port address.
REQ-006 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port Start, input, 1 bit: one-cycle request to begin a job; sampled only in IDLE.
REQ-009 SHALL have port Passes, input, CWIDTH bits: compare passes for the job; captured with Start.
REQ-010 SHALL have ports InValid (in, 1), InReady (out, 1), InData (in, WIDTH): load stream.
REQ-011 SHALL have ports OutValid (out, 1), OutReady (in, 1), OutData (out, WIDTH): unload stream.
REQ-012 SHALL have ports Busy (out, 1) and Done (out, 1): Done is a one-cycle job-complete pulse.
REQ-013 SHALL have ports HRD, HWR (out, 1), HAddr (out, GlobalAddrWidth), HDataOut (out, GlobalDataWidth): heap bus master outputs.
REQ-014 SHALL have port HDataIn, input, GlobalDataWidth bits: the heap bus read data.

Function
REQ-015 SHALL implement the states IDLE, LOAD, KICK, WAIT, UNLOAD and FINISH.
REQ-016 IDLE: Start=1 SHALL capture Passes, clear the word counter and enter LOAD; Start in any other state SHALL be ignored.
REQ-017 LOAD: InReady=1 SHALL hold; on each InValid&InReady cycle, drive HWR=1, HAddr=SCAN_ID and HDataOut=zero-extended InData in that same cycle.
REQ-018 LOAD: after NODES accepted words SHALL go to KICK; while InValid=0, HWR SHALL be 0 and no shift SHALL occur.
REQ-019 KICK: SHALL drive one cycle of HWR=1, HAddr=CTRL_ID, HDataOut=captured Passes, then go to WAIT.
REQ-020 KICK: if Passes==0, SHALL go directly to UNLOAD without the counter write.
REQ-021 WAIT: SHALL drive HRD=1, HAddr=CTRL_ID each cycle and sample HDataIn[CWIDTH-1:0].
REQ-022 WAIT: a sampled value of 0 SHALL move the FSM to UNLOAD on the next edge.
REQ-023 UNLOAD: SHALL assert HRD=1, HAddr=SCAN_ID for exactly one cycle per word.
REQ-024 UNLOAD: the captured HDataIn[WIDTH-1:0] SHALL be presented as OutData with OutValid=1 on the following cycle.
REQ-025 UNLOAD: the next read SHALL NOT issue until OutValid&OutReady; OutData SHALL stay stable while OutValid=1 and OutReady=0.
REQ-026 UNLOAD: after NODES words are accepted SHALL enter FINISH, which pulses Done=1 for one cycle and returns to IDLE.
REQ-027 HRD and HWR SHALL never both be 1; when neither is asserted, HAddr and HDataOut SHALL be 0.
REQ-028 Busy SHALL be 1 in every state except IDLE.
REQ-029 The word counter SHALL be 8 bits and compare against NODES-1, with no wrap-around within a job.

Reset
REQ-030 Reset=1 SHALL asynchronously force IDLE and clear the captured Passes and the counters.
REQ-031 Reset=1 SHALL asynchronously force InReady, OutValid, Busy, Done, HRD and HWR to 0, and OutData, HAddr and HDataOut to 0.
REQ-032 Reset asserted mid-job SHALL abandon the job with no further bus cycles; the heap contents are then undefined to the host.

Configuration
REQ-033 With macro BHEAP_SEQ_TIMEOUT_EN defined, a 16-bit WAIT watchdog SHALL clear on entry to WAIT; reaching 65535 SHALL abort to FINISH and pulse Done together with a one-cycle output port Timeout=1, with no UNLOAD.
REQ-034 Without BHEAP_SEQ_TIMEOUT_EN, no watchdog and no Timeout port SHALL exist, and WAIT SHALL wait indefinitely.

Verification
REQ-035 Reset mid-LOAD after 2 of 3 words -> next cycle all outputs are 0 and Busy=0.
REQ-036 Passes=2, load stream 5,9,1 (NODES=3) -> three load HWR cycles at SCAN_ID, one HWR at CTRL_ID with data 2, WAIT until the counter reads 0, then OutData 9 first, followed by the remaining two words; one Done pulse.
REQ-037 Passes=0 -> no CTRL_ID write; UNLOAD returns the loaded words in shift order.
REQ-038 InValid toggling 1,0,1,0,1 -> exactly 3 HWR scan cycles, none while InValid=0.
REQ-039 OutReady held 0 for 10 cycles during UNLOAD -> OutValid stays 1 with OutData constant and no extra HRD.
REQ-040 With BHEAP_SEQ_TIMEOUT_EN, HDataIn held at 1 -> after 65535 WAIT cycles Timeout and Done pulse together and the FSM returns to IDLE.
